jt49_psg: RTL and testbench

// - AY-3-8910-compatible programmable sound generator: 3 square-wave tone channels, 1 noise source, 1 envelope generator, 2 8-bit IO ports.
// - 16 CPU-visible registers. Per-channel log-scaled 8-bit outputs and a 10-bit mixed sum.
// - Sits behind a simple CPU bus (cs_n/wr_n/addr/din/dout) and feeds the audio path.

---
 rtl/jt49_psg_if.sv | 11 +
 rtl/jt49_psg.sv | 233 +++++++++++++++++++++++
 tb/tb_jt49_psg.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/jt49_psg_if.sv
// CPU bus of the PSG: register index, chip select, write strobe and data.
interface jt49_psg_if;
    logic [3:0] addr;
    logic       cs_n;
    logic       wr_n;
    logic [7:0] din;
    logic [7:0] dout;

    modport master (output addr, cs_n, wr_n, din, input  dout);
    modport slave  (input  addr, cs_n, wr_n, din, output dout);
endinterface

// File: rtl/jt49_psg.sv
// AY-3-8910 compatible PSG: three tone channels, one noise LFSR, one envelope
// generator, two IO ports and a log-scaled DAC per channel.
module jt49_psg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic        sel,
    jt49_psg_if.slave   bus,
    output logic [9:0]  sound,
    output logic [7:0]  A,
    output logic [7:0]  B,
    output logic [7:0]  C,
    output logic        sample,
    input  logic [7:0]  IOA_in,
    output logic [7:0]  IOA_out,
    output logic        IOA_oe,
    input  logic [7:0]  IOB_in,
    output logic [7:0]  IOB_out,
    output logic        IOB_oe
);
    logic [7:0]  regs_q [16], regs_d [16];
    logic        div2_q, div2_d;
    logic [3:0]  cen_cnt_q, cen_cnt_d;
    logic [11:0] tone_cnt_q [3], tone_cnt_d [3];
    logic [2:0]  tone_q, tone_d;
    logic [4:0]  noise_cnt_q, noise_cnt_d;
    logic [16:0] lfsr_q, lfsr_d;
    logic [15:0] env_cnt_q, env_cnt_d;
    logic [3:0]  env_pos_q, env_pos_d, env_hval_q, env_hval_d;
    logic        env_inv_q, env_inv_d, env_hold_q, env_hold_d;
    logic [7:0]  a_q, a_d, b_q, b_d, c_q, c_d;
    logic [9:0]  sound_q, sound_d;
    logic        sample_q, sample_d;

    logic        wr_en, cen, tick8, tick16, env_step;
    logic [11:0] tp [3];
    logic [4:0]  np;
    logic [15:0] ep;
    logic [3:0]  env_level;
    logic [3:0]  lvl [3];

    // Unused register bits are stored as zero so reads return them cleared.
    function automatic logic [7:0] wmask(input logic [3:0] a, input logic [7:0] d);
        case (a)
            4'd1, 4'd3, 4'd5, 4'd13:  return {4'd0, d[3:0]};
            4'd6, 4'd8, 4'd9, 4'd10:  return {3'd0, d[4:0]};
            default:                  return d;
        endcase
    endfunction

    // Logarithmic volume curve.
    function automatic logic [7:0] dac(input logic [3:0] v);
        case (v)
            4'd0:  return 8'd0;    4'd1:  return 8'd2;
            4'd2:  return 8'd3;    4'd3:  return 8'd4;
            4'd4:  return 8'd6;    4'd5:  return 8'd8;
            4'd6:  return 8'd11;   4'd7:  return 8'd16;
            4'd8:  return 8'd23;   4'd9:  return 8'd32;
            4'd10: return 8'd45;   4'd11: return 8'd64;
            4'd12: return 8'd90;   4'd13: return 8'd128;
            4'd14: return 8'd180;  default: return 8'd255;
        endcase
    endfunction

    // Register file writes; independent of clk_en.
    always_comb begin
        wr_en  = !bus.cs_n && !bus.wr_n;
        regs_d = regs_q;
        if (wr_en) regs_d[bus.addr] = wmask(bus.addr, bus.din);
    end

    // Read mux; IO registers read the pins while the port is an input.
    always_comb begin
        bus.dout = regs_q[bus.addr];
        if (bus.addr == 4'd14 && !regs_q[7][6]) bus.dout = IOA_in;
        if (bus.addr == 4'd15 && !regs_q[7][7]) bus.dout = IOB_in;
    end

    assign IOA_out = regs_q[14];
    assign IOA_oe  = regs_q[7][6];
    assign IOB_out = regs_q[15];
    assign IOB_oe  = regs_q[7][7];

    // Timebase: optional /2 of clk_en, then /8 and /16 tick strobes.
    always_comb begin
        cen       = clk_en & (sel | div2_q);
        div2_d    = clk_en ? ~div2_q : div2_q;
        cen_cnt_d = cen ? cen_cnt_q + 4'd1 : cen_cnt_q;
        tick8     = cen && (cen_cnt_q[2:0] == 3'd7);
        tick16    = cen && (cen_cnt_q == 4'd15);
    end

    // Effective periods; a programmed zero behaves as one.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            tp[i] = {regs_q[2*i+1][3:0], regs_q[2*i]};
            if (tp[i] == 12'd0) tp[i] = 12'd1;
        end
        np = (regs_q[6][4:0] == 5'd0) ? 5'd1 : regs_q[6][4:0];
        ep = ({regs_q[12], regs_q[11]} == 16'd0) ? 16'd1 : {regs_q[12], regs_q[11]};
    end

    // Tone dividers and noise LFSR, stepped on tick8.
    always_comb begin
        tone_cnt_d  = tone_cnt_q;
        tone_d      = tone_q;
        noise_cnt_d = noise_cnt_q;
        lfsr_d      = lfsr_q;
        if (tick8) begin
            for (int i = 0; i < 3; i++) begin
                if (tone_cnt_q[i] + 12'd1 >= tp[i]) begin
                    tone_cnt_d[i] = '0;
                    tone_d[i]     = ~tone_q[i];
                end else begin
                    tone_cnt_d[i] = tone_cnt_q[i] + 12'd1;
                end
            end
            if (noise_cnt_q + 5'd1 >= np) begin
                noise_cnt_d = '0;
                lfsr_d      = {lfsr_q[0] ^ lfsr_q[3], lfsr_q[16:1]};
            end else begin
                noise_cnt_d = noise_cnt_q + 5'd1;
            end
        end
    end

    // Envelope: position within a 16-step cycle, direction flip and hold.
    always_comb begin
        env_level  = env_hold_q ? env_hval_q :
                     ((regs_q[13][2] ^ env_inv_q) ? env_pos_q : ~env_pos_q);
        env_cnt_d  = env_cnt_q;
        env_pos_d  = env_pos_q;
        env_inv_d  = env_inv_q;
        env_hold_d = env_hold_q;
        env_hval_d = env_hval_q;
        env_step   = 1'b0;
        if (tick16) begin
            if (env_cnt_q + 16'd1 >= ep) begin
                env_cnt_d = '0;
                env_step  = 1'b1;
            end else begin
                env_cnt_d = env_cnt_q + 16'd1;
            end
        end
        if (env_step && !env_hold_q) begin
            if (env_pos_q != 4'd15) begin
                env_pos_d = env_pos_q + 4'd1;
            end else if (!regs_q[13][3]) begin
                env_hold_d = 1'b1;
                env_hval_d = 4'd0;
            end else if (regs_q[13][0]) begin
                env_hold_d = 1'b1;
                env_hval_d = regs_q[13][1] ? ~env_level : env_level;
            end else begin
                env_pos_d = 4'd0;
                if (regs_q[13][1]) env_inv_d = ~env_inv_q;
            end
        end
        // Writing the shape register restarts the envelope from the top.
        if (wr_en && bus.addr == 4'd13) begin
            env_cnt_d  = '0;
            env_pos_d  = '0;
            env_inv_d  = 1'b0;
            env_hold_d = 1'b0;
        end
    end

    // Mixer and amplitude; DAC outputs and sum latched on tick8.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            lvl[i] = ((tone_q[i] | regs_q[7][i]) & (lfsr_q[0] | regs_q[7][i+3])) ?
                     (regs_q[8+i][4] ? env_level : regs_q[8+i][3:0]) : 4'd0;
        end
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        sound_d  = sound_q;
        sample_d = tick8;
        if (tick8) begin
            a_d     = dac(lvl[0]);
            b_d     = dac(lvl[1]);
            c_d     = dac(lvl[2]);
            sound_d = {2'b00, a_d} + {2'b00, b_d} + {2'b00, c_d};
        end
    end

    assign A      = a_q;
    assign B      = b_q;
    assign C      = c_q;
    assign sound  = sound_q;
    assign sample = sample_q;

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
            for (int i = 0; i < 3; i++)  tone_cnt_q[i] <= '0;
            div2_q      <= 1'b0;
            cen_cnt_q   <= '0;
            tone_q      <= '0;
            noise_cnt_q <= '0;
            lfsr_q      <= 17'h1;
            env_cnt_q   <= '0;
            env_pos_q   <= '0;
            env_inv_q   <= 1'b0;
            env_hold_q  <= 1'b0;
            env_hval_q  <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            sound_q     <= '0;
            sample_q    <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            tone_cnt_q  <= tone_cnt_d;
            div2_q      <= div2_d;
            cen_cnt_q   <= cen_cnt_d;
            tone_q      <= tone_d;
            noise_cnt_q <= noise_cnt_d;
            lfsr_q      <= lfsr_d;
            env_cnt_q   <= env_cnt_d;
            env_pos_q   <= env_pos_d;
            env_inv_q   <= env_inv_d;
            env_hold_q  <= env_hold_d;
            env_hval_q  <= env_hval_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            sound_q     <= sound_d;
            sample_q    <= sample_d;
        end
    end
endmodule

// File: tb/tb_jt49_psg.sv
// Directed bench for jt49_psg: expected DAC samples are queued when a
// scenario is set up and popped whenever the PSG raises sample.
module tb_jt49_psg;
    logic       clk = 1'b0;
    logic       rst_n, clk_en, sel;
    logic [7:0] IOA_in, IOB_in, IOA_out, IOB_out, A, B, C;
    logic       IOA_oe, IOB_oe, sample;
    logic [9:0] sound;

    jt49_psg_if bus ();

    jt49_psg dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .sel(sel), .bus(bus),
        .sound(sound), .A(A), .B(B), .C(C), .sample(sample),
        .IOA_in(IOA_in), .IOA_out(IOA_out), .IOA_oe(IOA_oe),
        .IOB_in(IOB_in), .IOB_out(IOB_out), .IOB_oe(IOB_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] a;
        logic [9:0] snd;
    } exp_t;

    exp_t       exp_q[$];
    int         passed = 0;
    int         total  = 0;
    logic [7:0] dac_t [16] = '{8'd0, 8'd2, 8'd3, 8'd4, 8'd6, 8'd8, 8'd11, 8'd16,
                               8'd23, 8'd32, 8'd45, 8'd64, 8'd90, 8'd128, 8'd180, 8'd255};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // Scoreboard consumer.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && sample === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.tag, " A"}, {24'd0, A}, {24'd0, e.a});
            check({e.tag, " sound"}, {22'd0, sound}, {22'd0, e.snd});
        end
    end

    task automatic push(input string tag, input logic [7:0] a, input logic [9:0] snd);
        exp_t e;
        e.tag = tag; e.a = a; e.snd = snd;
        exp_q.push_back(e);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.addr = a; bus.din = d; bus.cs_n = 1'b0; bus.wr_n = 1'b0;
        @(negedge clk);
        bus.cs_n = 1'b1; bus.wr_n = 1'b1;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [7:0] expv);
        @(negedge clk);
        bus.addr = a; bus.cs_n = 1'b0; bus.wr_n = 1'b1;
        #1 check(tag, {24'd0, bus.dout}, {24'd0, expv});
        bus.cs_n = 1'b1;
    endtask

    task automatic do_reset();
        clk_en = 1'b0;
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        #1 check({tag, " drain"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Clocks between two consecutive sample pulses.
    task automatic meas(output int p);
        int n = 0;
        while (sample !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
        p = 1;
        while (sample !== 1'b1 && p < 200) begin @(negedge clk); p++; end
    endtask

    // Envelope level after s steps, written from the shape definition.
    function automatic int env_lvl(input logic [3:0] shp, input int s);
        int  p  = s % 16;
        int  c  = s / 16;
        bit  up;
        if (s < 16) return shp[2] ? s : 15 - s;
        if (!shp[3]) return 0;
        if (shp[0]) return (shp[2] ^ shp[1]) ? 15 : 0;
        up = shp[1] ? (shp[2] ^ c[0]) : shp[2];
        return up ? p : 15 - p;
    endfunction

    initial begin
        int         p, n, cnt;
        logic [16:0] lf;
        logic [3:0] shapes [4];
        shapes = '{4'h0, 4'hE, 4'hD, 4'hB};
        rst_n = 1'b0; clk_en = 1'b0; sel = 1'b1;
        IOA_in = 8'h00; IOB_in = 8'h00;
        bus.addr = '0; bus.din = '0; bus.cs_n = 1'b1; bus.wr_n = 1'b1;

        // Reset values.
        #12;
        check("rst A", {24'd0, A}, 0);
        check("rst B", {24'd0, B}, 0);
        check("rst C", {24'd0, C}, 0);
        check("rst sound", {22'd0, sound}, 0);
        check("rst dout", {24'd0, bus.dout}, 0);
        check("rst io", {14'd0, IOA_out, IOB_out, IOA_oe, IOB_oe}, 0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 16; i++) rd_chk($sformatf("rst r%0d", i), 4'(i), 8'h00);

        // Write masking.
        wr(4'd1, 8'hF2); wr(4'd0, 8'h34); wr(4'd13, 8'hFF); wr(4'd6, 8'hFF); wr(4'd8, 8'hFF);
        rd_chk("mask r1", 4'd1, 8'h02);
        rd_chk("mask r0", 4'd0, 8'h34);
        rd_chk("mask r13", 4'd13, 8'h0F);
        rd_chk("mask r6", 4'd6, 8'h1F);
        rd_chk("mask r8", 4'd8, 8'h1F);

        // Tone, sel=1, with a freeze in the middle.
        do_reset();
        wr(4'd0, 8'd1); wr(4'd1, 8'd0); wr(4'd7, 8'h3E); wr(4'd8, 8'h0F);
        for (int k = 1; k <= 8; k++) push("tone", (k % 2) ? 8'd0 : 8'd255, (k % 2) ? 10'd0 : 10'd255);
        sel = 1'b1;
        @(negedge clk) clk_en = 1'b1;
        n = 0;
        while (exp_q.size() > 4 && n < 500) begin @(negedge clk); n++; end
        clk_en = 1'b0;
        cnt = 0;
        for (int k = 0; k < 30; k++) begin @(negedge clk); if (sample) cnt++; end
        check("freeze samples", cnt, 0);
        check("freeze A", {24'd0, A}, 255);
        rd_chk("freeze read r8", 4'd8, 8'h0F);
        clk_en = 1'b1;
        drain("tone", 500);
        meas(p);
        check("tone sel1 spacing", p, 8);

        // Tone, sel=0: twice as slow.
        do_reset();
        wr(4'd0, 8'd1); wr(4'd7, 8'h3E); wr(4'd8, 8'h0F);
        for (int k = 1; k <= 4; k++) push("tone2", (k % 2) ? 8'd0 : 8'd255, (k % 2) ? 10'd0 : 10'd255);
        sel = 1'b0;
        @(negedge clk) clk_en = 1'b1;
        drain("tone2", 500);
        meas(p);
        check("tone sel0 spacing", p, 16);
        sel = 1'b1;

        // Envelope shapes, one step per two samples.
        foreach (shapes[j]) begin
            do_reset();
            wr(4'd11, 8'd1); wr(4'd12, 8'd0); wr(4'd7, 8'h3F); wr(4'd8, 8'h10);
            wr(4'd13, {4'd0, shapes[j]});
            for (int k = 1; k <= 72; k++) begin
                n = env_lvl(shapes[j], (k - 1) / 2);
                push($sformatf("env%0h s%0d", shapes[j], (k - 1) / 2), dac_t[n], {2'b00, dac_t[n]});
            end
            @(negedge clk) clk_en = 1'b1;
            drain("env", 1500);
        end

        // Noise on channel A against a bit0^bit3 LFSR model.
        do_reset();
        wr(4'd6, 8'd1); wr(4'd7, 8'h37); wr(4'd8, 8'h0F);
        lf = 17'h1;
        for (int k = 1; k <= 40; k++) begin
            push($sformatf("noise %0d", k), lf[0] ? 8'd255 : 8'd0, lf[0] ? 10'd255 : 10'd0);
            lf = {lf[0] ^ lf[3], lf[16:1]};
        end
        @(negedge clk) clk_en = 1'b1;
        drain("noise", 800);

        // Mixed sum of three fixed-volume channels.
        do_reset();
        wr(4'd7, 8'h3F); wr(4'd8, 8'h0F); wr(4'd9, 8'h08); wr(4'd10, 8'h0C);
        push("mix", 8'd255, 10'd368); push("mix", 8'd255, 10'd368);
        @(negedge clk) clk_en = 1'b1;
        drain("mix", 100);
        do_reset();
        wr(4'd7, 8'h3F); wr(4'd8, 8'h0F); wr(4'd9, 8'h0F); wr(4'd10, 8'h0F);
        push("max", 8'd255, 10'd765);
        @(negedge clk) clk_en = 1'b1;
        drain("max", 100);

        // IO ports.
        do_reset();
        wr(4'd7, 8'h40); wr(4'd14, 8'hA5);
        check("IOA_out", {24'd0, IOA_out}, 8'hA5);
        check("IOA_oe on", {31'd0, IOA_oe}, 1);
        rd_chk("r14 out", 4'd14, 8'hA5);
        IOA_in = 8'h3C;
        wr(4'd7, 8'h00);
        check("IOA_oe off", {31'd0, IOA_oe}, 0);
        rd_chk("r14 in", 4'd14, 8'h3C);
        IOB_in = 8'hC3;
        wr(4'd15, 8'h5A);
        rd_chk("r15 in", 4'd15, 8'hC3);
        wr(4'd7, 8'h80);
        check("IOB_out", {24'd0, IOB_out}, 8'h5A);
        check("IOB_oe on", {31'd0, IOB_oe}, 1);
        rd_chk("r15 out", 4'd15, 8'h5A);

        // Asynchronous reset while a tone is playing.
        do_reset();
        wr(4'd0, 8'd1); wr(4'd7, 8'h3E); wr(4'd8, 8'h0F);
        @(negedge clk) clk_en = 1'b1;
        n = 0;
        while (A !== 8'd255 && n < 200) begin @(negedge clk); n++; end
        check("pre-reset A", {24'd0, A}, 255);
        #2 rst_n = 1'b0;
        #1;
        check("async rst A", {24'd0, A}, 0);
        check("async rst sound", {22'd0, sound}, 0);
        bus.addr = 4'd8;
        #1 check("async rst r8", {24'd0, bus.dout}, 0);
        @(negedge clk) rst_n = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
